// File: rtl/pc_unit.sv
// Program-counter unit: fixed-priority next-PC selection, stall, exception EPC
// capture and a circular return-address stack that predicts return targets.
module pc_unit #(
    parameter int unsigned XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0180),
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned INC       = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           exc_req,
    input  logic                           branch_taken,
    input  logic [XLEN-1:0]                branch_target,
    input  logic                           jump,
    input  logic                           call,
    input  logic [XLEN-1:0]                jump_target,
    input  logic                           ret,
    input  logic [XLEN-1:0]                jr_target,
    output logic [XLEN-1:0]                pc_out,
    output logic [XLEN-1:0]                pc_plus,
    output logic [XLEN-1:0]                epc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [XLEN-1:0] ras_top;
    logic            ras_full;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_d;
    logic [PW-1:0]   ptr_d;
    logic [CW-1:0]   cnt_d;
    logic            ovf_d;
    logic            unf_d;
    logic            push;
    logic            pop;

    assign pc_plus  = pc_out + XLEN'(INC);
    assign ras_top  = ras_mem[ras_ptr - PW'(1)];
    assign ras_full = (ras_count == CW'(RAS_DEPTH));

    // Next-PC priority: exception > stall > branch > jump > return > sequential
    always_comb begin
        pc_d  = pc_out;
        epc_d = epc;
        ptr_d = ras_ptr;
        cnt_d = ras_count;
        ovf_d = ras_ovf;
        unf_d = ras_unf;
        push  = 1'b0;
        pop   = 1'b0;

        if (exc_req) begin
            pc_d  = EXC_VEC;
            epc_d = pc_out;
        end else if (!stall) begin
            if (branch_taken) begin
                pc_d = branch_target;
            end else if (jump) begin
                pc_d = jump_target;
                push = call;
            end else if (ret) begin
                if (ras_count != '0) begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end else begin
                    pc_d  = jr_target;
                    unf_d = 1'b1;
                end
            end else begin
                pc_d = pc_plus;
            end
        end

        // A push while full overwrites the oldest entry, which sits at the pointer
        if (push) begin
            ptr_d = ras_ptr + PW'(1);
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = ras_count + CW'(1);
            end
        end
        if (pop) begin
            ptr_d = ras_ptr - PW'(1);
            cnt_d = ras_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out    <= RESET_VEC;
            epc       <= '0;
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc_out    <= pc_d;
            epc       <= epc_d;
            ras_ptr   <= ptr_d;
            ras_count <= cnt_d;
            ras_ovf   <= ovf_d;
            ras_unf   <= unf_d;
        end
    end

    // Stack storage needs no reset; validity is tracked by ras_count
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_ptr] <= pc_plus;
        end
    end

endmodule
